// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock-divider scheduler: default ratio-field
// width, smallest legal divide ratio and the scheduler state encoding.
// Optional macro CLK_DIV_GATE_EN adds the GATED state to the encoding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int MIN_DIV   = 2;

`ifdef CLK_DIV_GATE_EN
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_GATED  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/clk_div_sched_if.sv
// -----------------------------------------------------------------------------
// clk_div_sched_if
// Ratio-request handshake and status bundle of the clock-divider scheduler.
//   cfg_valid  : new ratio request (master -> slave)
//   cfg_div    : requested ratio N (master -> slave)
//   cfg_ready  : request can be accepted (slave -> master)
//   busy       : an accepted ratio is pending application
//   cfg_err    : one-cycle pulse, illegal ratio rejected
//   div_active : ratio currently driving clk_out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface clk_div_sched_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             busy;
    logic             cfg_err;
    logic [DIV_W-1:0] div_active;

    modport master (
        output cfg_valid, cfg_div,
        input  cfg_ready, busy, cfg_err, div_active
    );

    modport slave (
        input  cfg_valid, cfg_div,
        output cfg_ready, busy, cfg_err, div_active
    );
endinterface

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Fixed-ratio 50%-duty divider: period counter 0..N-1 on clk posedge, a
// posedge phase flop and a negedge copy that stretches the high phase by half
// a source cycle when N is odd.
//   clk     : source clock
//   rst_n   : asynchronous active-low reset
//   i_run   : 1 = count; 0 = hold counter at 0 and output low
//   i_div   : divide ratio N (>= 2), only changed by the caller at a boundary
//   o_last  : counter is at N-1, so the coming posedge is a period boundary
//   o_clk   : divided clock
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_last,
    output logic             o_clk
);
    logic [DIV_W-1:0] r_cnt;
    logic             r_run;
    logic             r_pos;
    logic             r_neg;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_half;

    assign w_half = i_div >> 1;
    assign o_last = r_run && (r_cnt == i_div - 1'b1);

    // Coming out of reset or gating, the first enabled posedge is count 0
    // so that clk_out rises immediately.
    assign w_cnt_nxt = (!r_run || o_last) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_pos <= 1'b0;
        end else if (!i_run) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_pos <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_nxt;
            r_pos <= (w_cnt_nxt < w_half);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= r_pos;
        end
    end

    // Odd N: high for floor(N/2) posedge cycles plus the half cycle covered
    // by the negedge copy, giving exactly N/2 source periods.
    assign o_clk = i_div[0] ? (r_pos | r_neg) : r_pos;

endmodule

// File: rtl/clk_div_sched.sv
// -----------------------------------------------------------------------------
// clk_div_sched
// Glitch-free run-time ratio switching for clk_div_core. A legal request is
// held pending while the current output period finishes and is loaded at the
// next period boundary; ratios below MIN_DIV are rejected with cfg_err.
// Optional macro CLK_DIV_GATE_EN adds input en and the GATED state: en=0
// stops the output low at the next boundary, en=1 restarts it at once.
//   clk     : source clock
//   rst_n   : asynchronous active-low reset
//   en      : output enable (only with CLK_DIV_GATE_EN)
//   cfg     : ratio request / status bundle (clk_div_sched_if.slave)
//   clk_out : divided clock
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 3
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef CLK_DIV_GATE_EN
    input  logic           en,
`endif
    clk_div_sched_if.slave cfg,
    output logic           clk_out
);
    state_t           r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_err;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             w_last;
    logic             w_acc;
    logic             w_legal;
    logic             w_core_run;
`ifdef CLK_DIV_GATE_EN
    logic             r_has_pend;
`endif

    assign w_acc   = cfg.cfg_valid && r_ready;
    assign w_legal = (cfg.cfg_div >= DIV_W'(MIN_DIV));

`ifdef CLK_DIV_GATE_EN
    // Drop the core at the boundary posedge itself so no new period starts;
    // while gated the core follows en directly so it restarts on that edge.
    always_comb begin
        w_core_run = 1'b1;
        if (r_state == ST_GATED) begin
            w_core_run = en;
        end else if (w_last && !en) begin
            w_core_run = 1'b0;
        end
    end
`else
    assign w_core_run = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_div   <= DIV_W'(DEF_DIV);
            r_pend  <= DIV_W'(DEF_DIV);
`ifdef CLK_DIV_GATE_EN
            r_has_pend <= 1'b0;
`endif
        end else begin
            r_err <= w_acc && !w_legal;
            case (r_state)
                ST_RUN: begin
`ifdef CLK_DIV_GATE_EN
                    if (w_last && !en) begin
                        r_state <= ST_GATED;
                        r_ready <= 1'b1;
                        r_busy  <= w_acc && w_legal;
                        r_has_pend <= w_acc && w_legal;
                        if (w_acc && w_legal) begin
                            r_pend <= cfg.cfg_div;
                        end
                    end else if (w_acc && w_legal) begin
`else
                    if (w_acc && w_legal) begin
`endif
                        // Even when accepted on a boundary edge, the ratio
                        // waits for the following boundary.
                        r_pend  <= cfg.cfg_div;
                        r_state <= ST_SWITCH;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    if (w_last) begin
                        r_div   <= r_pend;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef CLK_DIV_GATE_EN
                        r_state <= en ? ST_RUN : ST_GATED;
`else
                        r_state <= ST_RUN;
`endif
                    end
                end
`ifdef CLK_DIV_GATE_EN
                ST_GATED: begin
                    if (en) begin
                        if (r_has_pend) begin
                            r_div <= r_pend;
                        end
                        r_has_pend <= 1'b0;
                        if (w_acc && w_legal) begin
                            r_pend  <= cfg.cfg_div;
                            r_state <= ST_SWITCH;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_acc && w_legal) begin
                        r_pend     <= cfg.cfg_div;
                        r_has_pend <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign cfg.cfg_ready  = r_ready;
    assign cfg.busy       = r_busy;
    assign cfg.cfg_err    = r_err;
    assign cfg.div_active = r_div;

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (w_core_run),
        .i_div  (r_div),
        .o_last (w_last),
        .o_clk  (clk_out)
    );

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divide-ratio field.
REQ-002 SHALL have parameter DEF_DIV, default 3, ratio loaded at reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL have port clk  input  1  the only clock, a 100 MHz source clock in the benches.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_valid  input  1  new ratio request.
REQ-006 SHALL have port cfg_div  input  DIV_W  requested ratio N.
REQ-007 SHALL have port cfg_ready  output  1  request can be accepted.
REQ-008 SHALL have port busy  output  1  an accepted ratio is pending application.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse, illegal ratio rejected.
REQ-010 SHALL have port div_active  output  DIV_W  ratio currently driving clk_out.
REQ-011 SHALL have port clk_out  output  1  divided clock.

Function
REQ-012 SHALL produce clk_out with period N*Tclk and high time exactly N*Tclk/2 for both odd and even N; rising edges coincide with clk posedge; odd N falling edge on clk negedge.
REQ-013 SHALL use a period counter 0..N-1 on clk posedge; wrap from N-1 to 0 is the period boundary, and clk_out rises at count 0.
REQ-014 SHALL implement states RUN and SWITCH; RUN: cfg_ready=1, busy=0; SWITCH: cfg_ready=0, busy=1.
REQ-015 SHALL accept a request on a posedge with cfg_valid&&cfg_ready; legal cfg_div moves to SWITCH and is latched as pending.
REQ-016 SHALL reject cfg_div<2: cfg_err=1 for the next cycle only, no state change, cfg_ready stays 1, div_active unchanged.
REQ-017 SHALL, in SWITCH, finish the current output period unchanged, load pending into div_active at the next boundary, start the new period there, and return to RUN in that same cycle.
REQ-018 SHALL treat a request accepted in the boundary cycle itself as applying at the following boundary (no truncated period).
REQ-019 SHALL accept a request equal to div_active and go through SWITCH with no visible change on clk_out.
REQ-020 SHALL never emit a high or low pulse shorter than Tclk/2 or longer than max(old,new)*Tclk/2 across a switch.

Reset
REQ-021 SHALL, while rst_n=0, drive clk_out=0, cfg_ready=0, busy=0, cfg_err=0, div_active=DEF_DIV, counter=0, state RUN; discard any pending ratio.
REQ-022 SHALL apply reset asynchronously, so clk_out falls in the same timestep as rst_n, including mid high phase.
REQ-023 SHALL raise cfg_ready on the first posedge after release; the first clk_out rise is on that same posedge.

Configuration
REQ-024 SHALL, with macro CLK_DIV_GATE_EN defined, add port en (input, 1) and state GATED: en=0 sampled at posedge sends the block to GATED at the next boundary, holding clk_out=0 and the counter at 0; cfg stays accepted and applies on exit.
REQ-025 SHALL, with CLK_DIV_GATE_EN defined, leave GATED on the posedge where en=1 is sampled; clk_out rises on that posedge.
REQ-026 SHALL, without CLK_DIV_GATE_EN, have no en port and no GATED state, and run continuously.

Structure
REQ-027 SHALL place the state enum, MIN_DIV=2 and the default DIV_W in package clk_div_pkg.
REQ-028 SHALL split out sub-module clk_div_core (counter plus posedge/negedge phase flops, fixed N input); clk_div_sched holds the handshake and state machine.

Verification
REQ-029 SHALL check: reset release with no cfg -> clk_out period 30 ns, high 15 ns, div_active=3, cfg_ready=1.
REQ-030 SHALL check: cfg_div=5 mid-period -> busy=1 and cfg_ready=0 until the boundary; the current 30 ns period completes; then period 50 ns, high 25 ns; div_active=5.
REQ-031 SHALL check: cfg_div=0, then 1 -> one-cycle cfg_err pulse each, div_active stays 3, and clk_out is undisturbed.
REQ-032 SHALL check: cfg_div=4, then 255 -> period 40/20 ns high, then 2550 ns period with 1275 ns high; no glitch at either switch.
REQ-033 SHALL check: rst_n low during a clk_out high phase at N=5 -> clk_out=0 in the same timestep; after release, N=3 timing resumes and the pending ratio is lost.
REQ-034 SHALL check, with CLK_DIV_GATE_EN: en=0 -> the current period completes, then clk_out=0; en=1 -> rise on the first sampling posedge with correct period.
